pipe_fetch: RTL and testbench
=============================

PIPE_FETCH -- requirements
Module: pipe_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0, giving the PC loaded at reset (bits [1:0] SHALL be treated as 0).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-006 mem_ack  input  1  memory response strobe, sampled on posedge clk while mem_req=1.
REQ-007 mem_data  input  32  instruction word, valid when mem_ack=1.
REQ-008 jump_e  input  1  one-cycle redirect pulse from execute (taken branch/JAL/JALR).
REQ-009 jump_pc  input  32  redirect target, valid when jump_e=1.
REQ-010 id_valid  output  1  decode-side entry available.
REQ-011 id_ready  input  1  decode stage accepts the head entry this cycle.
REQ-012 id_inst  output  32  instruction at FIFO head.
REQ-013 id_pc  output  32  PC of instruction at FIFO head.

Function
REQ-014 The block SHALL hold a fetch PC register, a 2-entry FIFO of {pc, inst}, and a 3-state FSM: IDLE, REQ, FLUSH.
REQ-015 IDLE->REQ SHALL occur when FIFO count is less than 2 and jump_e=0; mem_req SHALL be 1 exactly in REQ and FLUSH (registered, no combinational path from inputs).
REQ-016 At most one memory request SHALL be outstanding; mem_addr SHALL equal the fetch PC and SHALL remain stable from entry into REQ until the ack edge.
REQ-017 In REQ with mem_ack=1 and jump_e=0: push {PC, mem_data}, PC <= PC+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), FSM -> IDLE; minimum fetch latency 2 cycles, throughput 1 instruction per 2 cycles.
REQ-018 id_valid SHALL be 1 iff FIFO count > 0; id_inst/id_pc SHALL present the oldest entry; pop occurs on id_valid && id_ready.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; pushes SHALL never occur with count=2 (guaranteed by REQ-015).
REQ-020 jump_e=1 SHALL in the same edge clear the FIFO (id_valid=0 next cycle), load PC <= {jump_pc[31:2],2'b00}, and override any pop or push that cycle.
REQ-021 jump_e in IDLE: FSM stays IDLE for that edge, next request uses the new PC.
REQ-022 jump_e in REQ with mem_ack=0: FSM -> FLUSH; mem_req stays 1 with the old mem_addr until ack.
REQ-023 jump_e in REQ with mem_ack=1: response discarded, FSM -> IDLE.
REQ-024 In FLUSH, mem_ack=1 SHALL discard mem_data, not touch PC, and go to IDLE; a further jump_e in FLUSH SHALL update PC and remain in FLUSH (or go IDLE if acked that edge).
REQ-025 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-026 Asserting rst at any time, including mid-request or in FLUSH, SHALL immediately force: FSM=IDLE, PC=RESET_PC, FIFO count=0, mem_req=0, mem_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0.
REQ-027 After rst deasserts, the first mem_req SHALL rise on the first posedge clk following deassertion.

Verification
REQ-028 Reset, mem_ack one cycle after each mem_req, id_ready=1, RESET_PC=0 -> mem_addr sequence 0,4,8,C; id_pc matches with id_inst = mem_data returned for each address.
REQ-029 id_ready=0, continuous acks -> exactly 2 entries buffered (PCs 0,4), mem_req stays 0 while count=2; raising id_ready for one cycle -> head becomes PC 4, next fetch address 8.
REQ-030 jump_e with jump_pc=32'h103 while request to 8 outstanding, ack 3 cycles later with 32'hDEADBEEF -> that word never appears on id_inst; next mem_addr 32'h100; FIFO empty after jump.
REQ-031 jump_e and mem_ack on the same edge -> response dropped, next mem_addr = jump_pc; jump_e with id_ready=1 and id_valid=1 -> FIFO empty next cycle.
REQ-032 Jump to 32'hFFFFFFFC, acks continue -> fetch addresses FFFFFFFC then 00000000.
REQ-033 rst asserted asynchronously mid-REQ -> mem_req and id_valid fall before next clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction fetch front-end.
// Fetches one word at a time from instruction memory into a 2-entry
// {pc, inst} queue for decode. Execute can redirect the fetch PC at any
// time; a redirect discards the queue and any response still in flight.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        jump_e,
  input  logic [31:0] jump_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam int          DEPTH            = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Queue storage and bookkeeping
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        rd_ptr_q;
  logic        rd_ptr_d;
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic [DEPTH-1:0] wr_en;

  logic        push;
  logic        pop;
  logic [31:0] jump_target;

  // A redirect always wins over a push or a pop in the same cycle.
  assign jump_target = {jump_pc[31:2], 2'b00};
  assign push        = (state_q == ST_REQ) && mem_ack && !jump_e;
  assign pop         = (count_q != 2'd0) && id_ready && !jump_e;

  // One write strobe per queue slot, selected by the write pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_q == 1'(gi));
    end
  endgenerate

  // Next fetch PC: redirect target, or advance past a word just accepted.
  always_comb begin
    pc_d = pc_q;
    if (jump_e) begin
      pc_d = jump_target;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Next queue occupancy and pointers; a redirect empties the queue.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (jump_e) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch PC and queue control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC_ALIGNED;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue payload; cleared on reset so decode sees zeros while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= 32'd0;
        fifo_inst_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          fifo_pc_q[i]   <= pc_q;
          fifo_inst_q[i] <= mem_data;
        end
      end
    end
  end

  // Request FSM: issues one request at a time; FLUSH waits out a response
  // that a redirect made stale, keeping the old address on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC_ALIGNED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!jump_e && (count_q != 2'd2)) begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end else if (jump_e) begin
            state_q   <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign id_valid = (count_q != 2'd0);
  assign id_pc    = fifo_pc_q[rd_ptr_q];
  assign id_inst  = fifo_inst_q[rd_ptr_q];

endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed scenarios plus a randomized run checked against
// a queue-based reference model of the fetch stream.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        jump_e;
  logic [31:0] jump_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int tests = 0;
  int fails = 0;

  logic [31:0] req_log [$];
  logic [63:0] pop_log [$];

  pipe_fetch #(.RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .jump_e   (jump_e),
    .jump_pc  (jump_pc),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_inst  (id_inst),
    .id_pc    (id_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of an always-ready memory (ack one cycle after request)
  // while logging requested addresses and consumed entries.
  task automatic auto_cycle();
    if (mem_req && !mem_ack) begin
      req_log.push_back(mem_addr);
      mem_ack  = 1'b1;
      mem_data = memf(mem_addr);
    end else begin
      mem_ack  = 1'b0;
    end
    if (id_valid && id_ready) pop_log.push_back({id_pc, id_inst});
    tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mem_ack  = 1'b0;
    mem_data = 32'd0;
    jump_e   = 1'b0;
    jump_pc  = 32'd0;
    id_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    mem_ack  = 1'b1;
    mem_data = 32'hFFFFFFFF;
    jump_e   = 1'b0;
    jump_pc  = 32'd0;
    id_ready = 1'b1;
    tick();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 00000000", mem_addr); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    tests++; if (id_inst !== 32'h0) begin fails++; $display("FAIL reset_id_inst: got %h expected 00000000", id_inst); end
    tests++; if (id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc: got %h expected 00000000", id_pc); end
    mem_ack = 1'b0;
    rst     = 1'b0;
    tick();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL reset_first_req: got %b expected 1", mem_req); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_first_addr: got %h expected 00000000", mem_addr); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    do_reset();
    id_ready = 1'b1;
    for (int c = 0; c < 30; c++) auto_cycle();
    // One request every two cycles from the first edge after reset.
    tests++; if (req_log.size() != 15) begin fails++; $display("FAIL seq_req_count: got %0d expected 15", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      exp = 32'(4 * i);
      tests++;
      if (req_log.size() <= i) begin fails++; $display("FAIL seq_addr%0d: got none expected %h", i, exp); end
      else if (req_log[i] !== exp) begin fails++; $display("FAIL seq_addr%0d: got %h expected %h", i, req_log[i], exp); end
      tests++;
      if (pop_log.size() <= i) begin fails++; $display("FAIL seq_pop%0d: got none expected %h/%h", i, exp, memf(exp)); end
      else if (pop_log[i] !== {exp, memf(exp)}) begin
        fails++; $display("FAIL seq_pop%0d: got %h expected %h", i, pop_log[i], {exp, memf(exp)});
      end
    end
    $display("[TB] test_sequential done: %0d requests, %0d pops", req_log.size(), pop_log.size());
  endtask

  task automatic test_backpressure();
    bit seen;
    do_reset();
    id_ready = 1'b0;
    for (int c = 0; c < 12; c++) auto_cycle();
    tests++; if (req_log.size() != 2) begin fails++; $display("FAIL bp_req_count: got %0d expected 2", req_log.size()); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL bp_mem_req_full: got %b expected 0", mem_req); end
    tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL bp_id_valid: got %b expected 1", id_valid); end
    tests++; if (id_pc !== 32'h0 || id_inst !== memf(32'h0)) begin
      fails++; $display("FAIL bp_head0: got %h/%h expected 00000000/%h", id_pc, id_inst, memf(32'h0));
    end
    id_ready = 1'b1;
    auto_cycle();
    id_ready = 1'b0;
    tests++; if (id_pc !== 32'h4 || id_inst !== memf(32'h4)) begin
      fails++; $display("FAIL bp_head1: got %h/%h expected 00000004/%h", id_pc, id_inst, memf(32'h4));
    end
    req_log.delete();
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      auto_cycle();
      if (req_log.size() != 0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL bp_next_req: got no request expected 00000008"); end
    else if (req_log[0] !== 32'h8) begin fails++; $display("FAIL bp_next_req: got %h expected 00000008", req_log[0]); end
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_jump_outstanding();
    bit found;
    do_reset();
    id_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && !mem_ack && mem_addr == 32'h8) found = 1'b1;
      else auto_cycle();
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL jo_find_req8: got no request expected 00000008");
      return;
    end
    jump_e  = 1'b1;
    jump_pc = 32'h103;
    mem_ack = 1'b0;
    tick();
    jump_e = 1'b0;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL jo_fifo_empty: got %b expected 0", id_valid); end
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      fails++; $display("FAIL jo_hold_req: got %b/%h expected 1/00000008", mem_req, mem_addr);
    end
    tick();
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      fails++; $display("FAIL jo_hold_req_late: got %b/%h expected 1/00000008", mem_req, mem_addr);
    end
    mem_ack  = 1'b1;
    mem_data = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    req_log.delete();
    pop_log.delete();
    for (int c = 0; c < 12; c++) begin
      if (id_valid) begin
        tests++; if (id_inst === 32'hDEADBEEF) begin fails++; $display("FAIL jo_stale_word: got %h expected not deadbeef", id_inst); end
      end
      auto_cycle();
    end
    tests++;
    if (req_log.size() == 0) begin fails++; $display("FAIL jo_next_addr: got none expected 00000100"); end
    else if (req_log[0] !== 32'h100) begin fails++; $display("FAIL jo_next_addr: got %h expected 00000100", req_log[0]); end
    tests++;
    if (pop_log.size() == 0) begin fails++; $display("FAIL jo_first_pop: got none expected 00000100"); end
    else if (pop_log[0] !== {32'h100, memf(32'h100)}) begin
      fails++; $display("FAIL jo_first_pop: got %h expected %h", pop_log[0], {32'h100, memf(32'h100)});
    end
    $display("[TB] test_jump_outstanding done");
  endtask

  task automatic test_jump_with_ack();
    bit found;
    do_reset();
    id_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && !mem_ack && req_log.size() == 1) found = 1'b1;
      else auto_cycle();
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL jw_find_req: got no second request expected 00000004");
      return;
    end
    tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL jw_pre_valid: got %b expected 1", id_valid); end
    jump_e   = 1'b1;
    jump_pc  = 32'h200;
    mem_ack  = 1'b1;
    mem_data = memf(mem_addr);
    id_ready = 1'b1;
    tick();
    jump_e  = 1'b0;
    mem_ack = 1'b0;
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL jw_fifo_empty: got %b expected 0", id_valid); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL jw_req_done: got %b expected 0", mem_req); end
    req_log.delete();
    pop_log.delete();
    for (int c = 0; c < 10; c++) auto_cycle();
    tests++;
    if (req_log.size() == 0) begin fails++; $display("FAIL jw_next_addr: got none expected 00000200"); end
    else if (req_log[0] !== 32'h200) begin fails++; $display("FAIL jw_next_addr: got %h expected 00000200", req_log[0]); end
    tests++;
    if (pop_log.size() == 0) begin fails++; $display("FAIL jw_first_pop: got none expected 00000200"); end
    else if (pop_log[0] !== {32'h200, memf(32'h200)}) begin
      fails++; $display("FAIL jw_first_pop: got %h expected %h", pop_log[0], {32'h200, memf(32'h200)});
    end
    $display("[TB] test_jump_with_ack done");
  endtask

  task automatic test_wrap();
    do_reset();
    id_ready = 1'b1;
    tick();
    jump_e   = 1'b1;
    jump_pc  = 32'hFFFFFFFC;
    mem_ack  = 1'b1;
    mem_data = memf(mem_addr);
    tick();
    jump_e  = 1'b0;
    mem_ack = 1'b0;
    req_log.delete();
    pop_log.delete();
    for (int c = 0; c < 12; c++) auto_cycle();
    tests++;
    if (req_log.size() < 3) begin fails++; $display("FAIL wrap_addrs: got %0d requests expected at least 3", req_log.size()); end
    else if (req_log[0] !== 32'hFFFFFFFC || req_log[1] !== 32'h0 || req_log[2] !== 32'h4) begin
      fails++; $display("FAIL wrap_addrs: got %h,%h,%h expected fffffffc,00000000,00000004", req_log[0], req_log[1], req_log[2]);
    end
    tests++;
    if (pop_log.size() < 2) begin fails++; $display("FAIL wrap_pops: got %0d pops expected at least 2", pop_log.size()); end
    else if (pop_log[0] !== {32'hFFFFFFFC, memf(32'hFFFFFFFC)} || pop_log[1] !== {32'h0, memf(32'h0)}) begin
      fails++; $display("FAIL wrap_pops: got %h,%h expected %h,%h", pop_log[0], pop_log[1],
                        {32'hFFFFFFFC, memf(32'hFFFFFFFC)}, {32'h0, memf(32'h0)});
    end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    id_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req && !mem_ack && req_log.size() == 1) found = 1'b1;
      else auto_cycle();
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL ar_find_req: got no second request expected 00000004");
      return;
    end
    tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid: got %b expected 1", id_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL ar_mem_req: got %b expected 0", mem_req); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL ar_id_valid: got %b expected 0", id_valid); end
    tests++; if (mem_addr !== 32'h0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      fails++; $display("FAIL ar_outputs: got %h/%h/%h expected 0/0/0", mem_addr, id_pc, id_inst);
    end
    #1 rst = 1'b0;
    tick();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL ar_restart: got %b/%h expected 1/00000000", mem_req, mem_addr);
    end
    $display("[TB] test_async_reset done");
  endtask

  // Reference model: a queue of {pc, inst} the decode side should see,
  // a model fetch PC, and whether the outstanding request is still wanted.
  task automatic test_random();
    logic [63:0] q [$];
    logic [63:0] tmp;
    logic [31:0] model_pc;
    logic [31:0] req_addr;
    logic [31:0] tgt;
    bit          tracked;
    bit          stale;
    bit          jmp;
    bit          ack;
    bit          rdy;
    bit          pop;
    int          idle_run;
    int          n_jumps;
    int          n_pops;
    model_pc = 32'h0;
    req_addr = 32'h0;
    tracked  = 1'b0;
    stale    = 1'b0;
    idle_run = 0;
    n_jumps  = 0;
    n_pops   = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tests++;
      if (id_valid !== (q.size() != 0)) begin
        fails++; $display("FAIL rnd_id_valid cyc %0d: got %b expected %b", c, id_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        tests++;
        if ({id_pc, id_inst} !== q[0]) begin
          fails++; $display("FAIL rnd_head cyc %0d: got %h/%h expected %h/%h", c, id_pc, id_inst, q[0][63:32], q[0][31:0]);
        end
      end
      if (mem_req && !tracked) begin
        tests++;
        if (mem_addr !== model_pc) begin
          fails++; $display("FAIL rnd_fetch_addr cyc %0d: got %h expected %h", c, mem_addr, model_pc);
        end
        tests++;
        if (q.size() >= 2) begin
          fails++; $display("FAIL rnd_req_when_full cyc %0d: got request with %0d entries expected none", c, q.size());
        end
        tracked  = 1'b1;
        stale    = 1'b0;
        req_addr = mem_addr;
      end else if (mem_req) begin
        tests++;
        if (mem_addr !== req_addr) begin
          fails++; $display("FAIL rnd_addr_stable cyc %0d: got %h expected %h", c, mem_addr, req_addr);
        end
      end else if (tracked) begin
        tests++; fails++;
        $display("FAIL rnd_req_dropped cyc %0d: got mem_req 0 expected 1 for %h", c, req_addr);
        tracked = 1'b0;
      end
      if (mem_req || q.size() == 2) idle_run = 0;
      else idle_run++;
      tests++;
      if (idle_run > 2) begin
        fails++; $display("FAIL rnd_stall cyc %0d: got %0d idle cycles expected at most 2", c, idle_run);
        idle_run = 0;
      end

      jmp = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        2:       tgt = 32'($urandom_range(0, 255));
        default: tgt = $urandom & 32'hFFFF0FFF;
      endcase
      jump_e   = jmp;
      jump_pc  = tgt;
      id_ready = rdy;
      mem_ack  = ack;
      mem_data = mem_req ? memf(mem_addr) : $urandom;

      pop = (q.size() != 0) && rdy && !jmp;
      if (jmp) begin
        n_jumps++;
        q.delete();
        model_pc = {tgt[31:2], 2'b00};
        idle_run = 0;
        if (tracked) begin
          if (ack) tracked = 1'b0;
          else     stale   = 1'b1;
        end
      end else begin
        if (pop) begin
          tmp = q.pop_front();
          n_pops++;
        end
        if (tracked && ack) begin
          if (!stale) begin
            q.push_back({model_pc, memf(req_addr)});
            model_pc = model_pc + 32'd4;
          end
          tracked = 1'b0;
        end
      end
      tick();
    end
    jump_e   = 1'b0;
    mem_ack  = 1'b0;
    id_ready = 1'b0;
    $display("[TB] test_random done: %0d jumps, %0d pops, last head %h", n_jumps, n_pops, tmp);
  endtask

  initial begin
    rst      = 1'b1;
    mem_ack  = 1'b0;
    mem_data = 32'd0;
    jump_e   = 1'b0;
    jump_pc  = 32'd0;
    id_ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_outstanding();
    test_jump_with_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
